// File: rtl/stack_pkg.sv
// Shared defaults and command encoding for the stack unit.
package stack_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_PTR_W  = $clog2(DEF_DEPTH);

    typedef enum logic [2:0] {
        CMD_NONE    = 3'd0,
        CMD_PUSH    = 3'd1,
        CMD_POP     = 3'd2,
        CMD_TOS     = 3'd3,
        CMD_ILLEGAL = 3'd4
    } cmd_e;

    // More than one strobe in the same cycle is illegal, not a priority pick.
    function automatic cmd_e decode_cmd(input logic push, input logic pop, input logic tos);
        case ({tos, pop, push})
            3'b000:  decode_cmd = CMD_NONE;
            3'b001:  decode_cmd = CMD_PUSH;
            3'b010:  decode_cmd = CMD_POP;
            3'b100:  decode_cmd = CMD_TOS;
            default: decode_cmd = CMD_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack entry storage: synchronous write, combinational read, deliberately not reset.
module stack_mem
    import stack_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// LIFO stack controller: command decode, boundary checks, pointer and registered read data.
module stack_unit
    import stack_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       tos,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic                       done,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]      sp;
    logic [DATA_W-1:0]   rdata;
    logic [PTR_W-1:0]    raddr;
    cmd_e                cmd;
    logic                accept_push;
    logic                accept_read;
    logic                do_pop;
    logic                reject;

    assign cmd   = decode_cmd(push, pop, tos);
    assign count = sp;
    assign full  = (sp == (PTR_W+1)'(DEPTH));
    assign empty = (sp == '0);
    // Only meaningful when not empty; wraps harmlessly at sp == 0.
    assign raddr = sp[PTR_W-1:0] - PTR_W'(1);

    always_comb begin
        accept_push = 1'b0;
        accept_read = 1'b0;
        do_pop      = 1'b0;
        reject      = 1'b0;
        case (cmd)
            CMD_PUSH: begin
                if (full) reject = 1'b1;
                else      accept_push = 1'b1;
            end
            CMD_POP: begin
                if (empty) reject = 1'b1;
                else begin
                    accept_read = 1'b1;
                    do_pop      = 1'b1;
                end
            end
            CMD_TOS: begin
                if (empty) reject = 1'b1;
                else       accept_read = 1'b1;
            end
            CMD_ILLEGAL: reject = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp   <= '0;
            dout <= '0;
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            if (accept_push) begin
                sp <= sp + (PTR_W+1)'(1);
            end else if (do_pop) begin
                sp <= sp - (PTR_W+1)'(1);
            end
            if (accept_read) begin
                dout <= rdata;
            end
            done <= accept_push | accept_read;
            if (reject) begin
                err <= 1'b1;
            end
        end
    end

    stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (accept_push),
        .waddr (sp[PTR_W-1:0]),
        .wdata (din),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit with hand-computed expected values.
module tb_stack_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       push, pop, tos;
    logic [7:0] din;
    logic [7:0] dout;
    logic       done, full, empty, err;
    logic [3:0] count;

    int vectors     = 0;
    int miscompares = 0;

    stack_unit dut (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .tos   (tos),
        .din   (din),
        .dout  (dout),
        .done  (done),
        .full  (full),
        .empty (empty),
        .count (count),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [7:0] v);
        push = 1'b1; din = v;
        tick();
        push = 1'b0;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic do_tos();
        tos = 1'b1;
        tick();
        tos = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        tick();
        #2 rst = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; push = 1'b0; pop = 1'b0; tos = 1'b0; din = 8'h00;
        tick(); tick();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full",  full,  0);
        chk("rst_dout",  dout,  0);
        chk("rst_done",  done,  0);
        chk("rst_err",   err,   0);
        #2 rst = 1'b1;
        tick();

        // underflow from reset, then legal traffic with sticky err
        do_pop();
        chk("uf_done", done, 0);
        chk("uf_err",  err,  1);
        chk("uf_dout", dout, 8'h00);
        do_push(8'h5C);
        chk("uf_push_done", done, 1);
        do_pop();
        chk("uf_pop_dout", dout, 8'h5C);
        chk("uf_pop_done", done, 1);
        chk("uf_err_sticky", err, 1);

        do_reset();
        do_push(8'h11);
        chk("p1_done", done, 1);
        chk("p1_count", count, 1);
        do_push(8'h22);
        chk("p2_done", done, 1);
        chk("p2_count", count, 2);
        do_push(8'h33);
        chk("p3_done", done, 1);
        chk("p3_count", count, 3);
        do_pop();
        chk("pop33_dout", dout, 8'h33);
        chk("pop33_count", count, 2);
        chk("pop33_done", done, 1);
        tick();
        chk("idle_done", done, 0);
        chk("idle_dout_hold", dout, 8'h33);
        do_pop();
        chk("pop22_dout", dout, 8'h22);
        do_pop();
        chk("pop11_dout", dout, 8'h11);
        chk("pop11_empty", empty, 1);
        chk("seq_err", err, 0);

        do_push(8'hA5);
        do_tos();
        chk("tos1_dout", dout, 8'hA5);
        chk("tos1_count", count, 1);
        chk("tos1_done", done, 1);
        do_tos();
        chk("tos2_dout", dout, 8'hA5);
        chk("tos2_count", count, 1);
        do_pop();
        chk("tospop_dout", dout, 8'hA5);
        chk("tospop_empty", empty, 1);
        chk("tospop_count", count, 0);

        for (int i = 1; i <= 8; i++) begin
            do_push(8'(i));
        end
        chk("fill_full", full, 1);
        chk("fill_count", count, 8);
        chk("fill_err", err, 0);
        do_push(8'hFF);
        chk("of_done", done, 0);
        chk("of_err", err, 1);
        chk("of_count", count, 8);
        chk("of_full", full, 1);
        for (int i = 8; i >= 1; i--) begin
            do_pop();
            chk("drain_dout", dout, 32'(i));
        end
        chk("drain_empty", empty, 1);

        do_reset();
        do_push(8'h41);
        do_push(8'h42);
        do_tos();
        chk("ill_pre_err", err, 0);
        push = 1'b1; pop = 1'b1; din = 8'h99;
        tick();
        push = 1'b0; pop = 1'b0;
        chk("ill_count", count, 2);
        chk("ill_done", done, 0);
        chk("ill_err", err, 1);
        chk("ill_dout", dout, 8'h42);
        do_pop();
        chk("ill_after_dout", dout, 8'h42);
        do_pop();
        chk("ill_after2_dout", dout, 8'h41);

        do_reset();
        do_push(8'h01);
        do_push(8'h02);
        do_push(8'h03);
        do_tos();
        chk("ar_pre_count", count, 3);
        push = 1'b1; din = 8'h04;
        #3 rst = 1'b0;
        #1;
        chk("ar_count", count, 0);
        chk("ar_empty", empty, 1);
        chk("ar_full",  full,  0);
        chk("ar_dout",  dout,  0);
        chk("ar_done",  done,  0);
        chk("ar_err",   err,   0);
        push = 1'b0;
        tick();
        #2 rst = 1'b1;
        tick();
        chk("ar_rel_done", done, 0);
        do_pop();
        chk("ar_uf_err",  err,  1);
        chk("ar_uf_done", done, 0);
        chk("ar_uf_dout", dout, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
